// File: rtl/custom_instr_pkg.sv
// Shared types for the custom-instruction coprocessor: commit-table states and the
// result record carried from the execution FSM to the CV-X-IF result channel.
package custom_instr_pkg;

  localparam int unsigned X_ID_WIDTH = 4;

  typedef enum logic [1:0] {
    CMT_NONE,
    CMT_COMMIT,
    CMT_KILL
  } commit_state_e;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [31:0]           data;
    logic [4:0]            rd;
    logic                  we;
  } coproc_result_t;

endpackage

// File: rtl/coproc_commit_table.sv
// Per-id commit/kill state recorded from the core's commit interface. A set and a
// clear of the same id in one cycle resolves in favour of the set.
module coproc_commit_table
  import custom_instr_pkg::*;
#(
  parameter int unsigned ID_WIDTH = X_ID_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                set_i,
  input  logic [ID_WIDTH-1:0] set_id_i,
  input  logic                set_kill_i,
  input  logic                clr_a_i,
  input  logic [ID_WIDTH-1:0] clr_a_id_i,
  input  logic                clr_b_i,
  input  logic [ID_WIDTH-1:0] clr_b_id_i,
  input  logic [ID_WIDTH-1:0] rd_a_id_i,
  output commit_state_e       rd_a_o,
  input  logic [ID_WIDTH-1:0] rd_b_id_i,
  output commit_state_e       rd_b_o
);

  localparam int unsigned NumIds = 1 << ID_WIDTH;

  commit_state_e state_q [NumIds];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumIds; i++) state_q[i] <= CMT_NONE;
    end else begin
      for (int unsigned i = 0; i < NumIds; i++) begin
        if (set_i && set_id_i == ID_WIDTH'(i)) begin
          state_q[i] <= set_kill_i ? CMT_KILL : CMT_COMMIT;
        end else if ((clr_a_i && clr_a_id_i == ID_WIDTH'(i)) ||
                     (clr_b_i && clr_b_id_i == ID_WIDTH'(i))) begin
          state_q[i] <= CMT_NONE;
        end
      end
    end
  end

  assign rd_a_o = state_q[rd_a_id_i];
  assign rd_b_o = state_q[rd_b_id_i];

endmodule

// File: rtl/coproc_result_q.sv
// In-order result buffer between the coprocessor execution FSM and the CV-X-IF result
// channel; entries leave only once their id is committed (emitted) or killed (dropped).
module coproc_result_q
  import custom_instr_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ID_WIDTH = X_ID_WIDTH
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [ID_WIDTH-1:0]        in_id_i,
  input  logic [31:0]                in_data_i,
  input  logic [4:0]                 in_rd_i,
  input  logic                       in_we_i,
  input  logic                       commit_valid_i,
  input  logic [ID_WIDTH-1:0]        commit_id_i,
  input  logic                       commit_kill_i,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output logic [ID_WIDTH-1:0]        result_id_o,
  output logic [31:0]                result_data_o,
  output logic [4:0]                 result_rd_o,
  output logic                       result_we_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  coproc_result_t  mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  coproc_result_t      head;
  logic [ID_WIDTH-1:0] head_id;
  commit_state_e       head_st, in_st;
  logic                not_empty, push, drop_in, store, kill_pop, pop;

  assign head      = mem_q[rd_ptr_q];
  assign head_id   = ID_WIDTH'(head.id);
  assign not_empty = count_q != '0;

  // Ready looks only at the registered count, never at this cycle's pop.
  assign in_ready_o = count_q < CntW'(DEPTH);
  assign push       = in_valid_i & in_ready_o;
  assign drop_in    = push & (in_st == CMT_KILL);
  assign store      = push & ~drop_in;

  assign result_valid_o = not_empty & (head_st == CMT_COMMIT);
  assign kill_pop       = not_empty & (head_st == CMT_KILL);
  assign pop            = kill_pop | (result_valid_o & result_ready_i);

  coproc_commit_table #(
    .ID_WIDTH (ID_WIDTH)
  ) u_commit_table (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .set_i      (commit_valid_i),
    .set_id_i   (commit_id_i),
    .set_kill_i (commit_kill_i),
    .clr_a_i    (pop),
    .clr_a_id_i (head_id),
    .clr_b_i    (drop_in),
    .clr_b_id_i (in_id_i),
    .rd_a_id_i  (head_id),
    .rd_a_o     (head_st),
    .rd_b_id_i  (in_id_i),
    .rd_b_o     (in_st)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (store) begin
      mem_q[wr_ptr_q] <= '{id: X_ID_WIDTH'(in_id_i), data: in_data_i, rd: in_rd_i,
                           we: in_we_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (store) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({store, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign result_id_o   = head_id;
  assign result_data_o = head.data;
  assign result_rd_o   = head.rd;
  assign result_we_o   = head.we;
  assign count_o       = count_q;

endmodule

// File: tb/tb_coproc_result_q.sv
// Scoreboard bench for coproc_result_q: results expected to reach the core are queued at
// enqueue time and compared in order as the DUT offers them.
module tb_coproc_result_q;
  import custom_instr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_id = '0;
  logic [31:0] in_data = '0;
  logic [4:0]  in_rd = '0;
  logic        in_we = 1'b0;
  logic        commit_valid = 1'b0;
  logic [3:0]  commit_id = '0;
  logic        commit_kill = 1'b0;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic [3:0]  result_id;
  logic [31:0] result_data;
  logic [4:0]  result_rd;
  logic        result_we;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;
  coproc_result_t exp_q[$];

  always #5 clk = ~clk;

  coproc_result_q #(
    .DEPTH    (4),
    .ID_WIDTH (4)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_id_i        (in_id),
    .in_data_i      (in_data),
    .in_rd_i        (in_rd),
    .in_we_i        (in_we),
    .commit_valid_i (commit_valid),
    .commit_id_i    (commit_id),
    .commit_kill_i  (commit_kill),
    .result_valid_o (result_valid),
    .result_ready_i (result_ready),
    .result_id_o    (result_id),
    .result_data_o  (result_data),
    .result_rd_o    (result_rd),
    .result_we_o    (result_we),
    .count_o        (count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [3:0] id, input logic [31:0] data, input logic [4:0] rd,
                     input logic we, input bit emit);
    coproc_result_t r;
    r = '{id: id, data: data, rd: rd, we: we};
    check("enq_ready", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_id    = id;
    in_data  = data;
    in_rd    = rd;
    in_we    = we;
    if (emit) exp_q.push_back(r);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    commit_valid = 1'b1;
    commit_id    = id;
    commit_kill  = kill;
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic compare_head(input string tag);
    coproc_result_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, {28'b0, result_id}, 32'hffff_ffff);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_id"}, {28'b0, result_id}, {28'b0, e.id});
      check({tag, "_data"}, result_data, e.data);
      check({tag, "_rd"}, {27'b0, result_rd}, {27'b0, e.rd});
      check({tag, "_we"}, {31'b0, result_we}, {31'b0, e.we});
    end
  endtask

  // Accept one result within a bounded number of cycles.
  task automatic drain_one(input string tag);
    bit done = 0;
    result_ready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (result_valid) begin
        compare_head(tag);
        done = 1;
      end
      tick();
    end
    result_ready = 1'b0;
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    tick();
    check("rst_ready", {31'b0, in_ready}, 32'd1);
    check("rst_valid", {31'b0, result_valid}, 32'd0);
    check("rst_count", {29'b0, count}, 32'd0);
    check("rst_data", result_data, 32'd0);
    check("rst_id", {28'b0, result_id}, 32'd0);
    check("rst_rdwe", {26'b0, result_rd, result_we}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic enqueue then commit two cycles later.
    enq(4'd3, 32'hDEAD_BEEF, 5'd5, 1'b1, 1);
    check("s1_count1", {29'b0, count}, 32'd1);
    check("s1_wait", {31'b0, result_valid}, 32'd0);
    tick();
    commit(4'd3, 1'b0);
    check("s1_valid", {31'b0, result_valid}, 32'd1);
    drain_one("s1");
    check("s1_count0", {29'b0, count}, 32'd0);

    // Commit before enqueue: valid the cycle after enqueue.
    commit(4'd7, 1'b0);
    enq(4'd7, 32'h0000_7777, 5'd7, 1'b0, 1);
    check("s2_valid", {31'b0, result_valid}, 32'd1);
    drain_one("s2");

    // Kill before enqueue: swallowed, and the table entry is freed for reuse.
    commit(4'd2, 1'b1);
    enq(4'd2, 32'h0000_2222, 5'd2, 1'b1, 0);
    check("s2k_count", {29'b0, count}, 32'd0);
    check("s2k_valid", {31'b0, result_valid}, 32'd0);
    enq(4'd2, 32'h0000_2223, 5'd3, 1'b1, 1);
    check("s2k_reuse", {29'b0, count}, 32'd1);
    commit(4'd2, 1'b0);
    drain_one("s2k");

    // Fill, then an uncommitted head blocks younger committed entries.
    for (int i = 1; i <= 4; i++) enq(4'(i), 32'hA000_0000 | i, 5'(i + 10), 1'b1, 1);
    check("s3_full", {31'b0, in_ready}, 32'd0);
    check("s3_count", {29'b0, count}, 32'd4);
    commit(4'd2, 1'b0);
    commit(4'd3, 1'b0);
    commit(4'd4, 1'b0);
    tick();
    check("s3_blocked", {31'b0, result_valid}, 32'd0);
    commit(4'd1, 1'b0);
    for (int i = 0; i < 4; i++) drain_one("s3");
    check("s3_empty", {29'b0, count}, 32'd0);

    // Kill at head is dropped silently, then the committed follower is emitted.
    enq(4'd5, 32'h0000_5555, 5'd5, 1'b1, 0);
    enq(4'd6, 32'h0000_6666, 5'd6, 1'b0, 1);
    commit(4'd5, 1'b1);
    check("s4_killhead", {31'b0, result_valid}, 32'd0);
    check("s4_count2", {29'b0, count}, 32'd2);
    commit(4'd6, 1'b0);
    check("s4_count1", {29'b0, count}, 32'd1);
    check("s4_valid6", {31'b0, result_valid}, 32'd1);
    drain_one("s4");

    // Back-pressure: valid and fields hold while ready is low.
    enq(4'd8, 32'h1234_5678, 5'd18, 1'b1, 1);
    commit(4'd8, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("s5_hold_valid", {31'b0, result_valid}, 32'd1);
      check("s5_hold_data", result_data, exp_q[0].data);
      check("s5_hold_id", {28'b0, result_id}, {28'b0, exp_q[0].id});
      tick();
    end
    drain_one("s5");

    // Push and pop in the same cycle at count 2.
    enq(4'd9, 32'h0000_9999, 5'd9, 1'b1, 1);
    enq(4'd10, 32'h0000_AAAA, 5'd10, 1'b1, 0);
    commit(4'd9, 1'b0);
    check("s6_count2", {29'b0, count}, 32'd2);
    check("s6_valid", {31'b0, result_valid}, 32'd1);
    compare_head("s6");
    result_ready = 1'b1;
    in_valid = 1'b1;
    in_id = 4'd11;
    in_data = 32'h0000_BBBB;
    tick();
    result_ready = 1'b0;
    in_valid = 1'b0;
    check("s6_count_same", {29'b0, count}, 32'd2);

    // Asynchronous reset with three entries queued and a committed head.
    enq(4'd12, 32'h0000_CCCC, 5'd12, 1'b1, 0);
    commit(4'd10, 1'b0);
    check("s7_pre_count", {29'b0, count}, 32'd3);
    check("s7_pre_valid", {31'b0, result_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("s7_rst_valid", {31'b0, result_valid}, 32'd0);
    check("s7_rst_count", {29'b0, count}, 32'd0);
    check("s7_rst_ready", {31'b0, in_ready}, 32'd1);
    check("s7_rst_data", result_data, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    commit(4'd10, 1'b0);
    commit(4'd11, 1'b0);
    commit(4'd12, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("s7_no_emit", {31'b0, result_valid}, 32'd0);
      tick();
    end
    check("s7_count", {29'b0, count}, 32'd0);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
